// File: rtl/store_write_buffer.sv
// Write-through store buffer: queues pipeline stores, drains them to memory
// whenever the cache fill path is idle, merges repeats and flags block conflicts.
module store_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_req,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_full,
  input  logic        fill_busy,
  input  logic        rd_check,
  input  logic [15:0] rd_addr,
  output logic        conflict,
  input  logic        flush_req,
  output logic        flush_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        empty,
  output logic [3:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {IDLE, FLUSH} state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } entry_t;

  entry_t             entries [DEPTH];
  logic [PTR_W-1:0]   head, tail, newest, scan_idx;
  logic [3:0]         count_q;
  state_t             state, state_nxt;
  logic               drain, merge_hit, enq, block_hit;
  logic               unused_rd_low;

  assign unused_rd_low = ^rd_addr[3:0];

  always_comb begin
    newest    = tail - PTR_W'(1);
    drain     = (count_q != 4'd0) && !fill_busy;
    // The newest entry is only being drained when it is also the oldest one.
    merge_hit = wr_req && !flush_req && (count_q != 4'd0) &&
                (entries[newest].addr[15:1] == wr_addr[15:1]) &&
                !(drain && (count_q == 4'd1));
    wr_full   = ((count_q == 4'(DEPTH)) && !merge_hit) || flush_req;
    enq       = wr_req && !wr_full && !merge_hit;
  end

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    scan_idx  = head;
    block_hit = wr_req && (wr_addr[15:4] == rd_addr[15:4]);
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PTR_W'(i);
      if ((4'(i) < count_q) && (entries[scan_idx].addr[15:4] == rd_addr[15:4]))
        block_hit = 1'b1;
    end
    conflict = rd_check && block_hit;
  end

  always_comb begin
    mem_en   = drain;
    mem_wr   = drain;
    mem_addr = drain ? entries[head].addr : '0;
    mem_data = drain ? entries[head].data : '0;
    empty    = (count_q == 4'd0);
    count    = count_q;
  end

  always_comb begin
    state_nxt  = state;
    flush_done = 1'b0;
    case (state)
      IDLE: if (flush_req) state_nxt = FLUSH;
      FLUSH: begin
        if (!flush_req) begin
          state_nxt = IDLE;
        end else if (count_q == 4'd0) begin
          flush_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      state   <= IDLE;
    end else begin
      if (enq)   tail <= tail + PTR_W'(1);
      if (drain) head <= head + PTR_W'(1);
      count_q <= count_q + {3'b000, enq} - {3'b000, drain};
      state   <= state_nxt;
    end
  end

  // NOTE: the entry storage is deliberately not reset; validity comes from count and the pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      entries[tail].addr <= wr_addr;
      entries[tail].data <= wr_data;
    end
    if (merge_hit)
      entries[newest].data <= wr_data;
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed and randomized bench for store_write_buffer, compared every cycle
// against a queue-based reference model.
module tb_store_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req, fill_busy, rd_check, flush_req;
  logic [15:0] wr_addr, wr_data, rd_addr;
  logic        wr_full, conflict, flush_done, mem_en, mem_wr, empty;
  logic [15:0] mem_addr, mem_data;
  logic [3:0]  count;

  int errors   = 0;
  int n_checks = 0;

  logic [15:0] q_addr[$];
  logic [15:0] q_data[$];
  bit          m_flush;

  logic        obs_full, obs_cfl, obs_fd, obs_wr;
  logic [15:0] obs_maddr, obs_mdata;
  int          pulses;

  store_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_full(wr_full),
    .fill_busy(fill_busy), .rd_check(rd_check), .rd_addr(rd_addr), .conflict(conflict),
    .flush_req(flush_req), .flush_done(flush_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_req = 0; fill_busy = 0; rd_check = 0; flush_req = 0;
    wr_addr = 0; wr_data = 0; rd_addr = 0;
    @(posedge clk);
    q_addr.delete();
    q_data.delete();
    m_flush = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: apply inputs, compare outputs with the model, advance the model.
  task automatic step(input logic wr, input logic [15:0] wa, input logic [15:0] wd,
                      input logic fb, input logic rc, input logic [15:0] ra, input logic fr);
    bit drn, mrg, full, acc, cfl, fd;
    logic [15:0] ea, ed;
    int n;
    wr_req = wr; wr_addr = wa; wr_data = wd;
    fill_busy = fb; rd_check = rc; rd_addr = ra; flush_req = fr;
    #1;
    n    = q_addr.size();
    drn  = (n != 0) && !fb;
    mrg  = wr && !fr && (n != 0) && (q_addr[n-1][15:1] == wa[15:1]) && !(drn && n == 1);
    full = ((n == DEPTH) && !mrg) || fr;
    acc  = wr && !full && !mrg;
    cfl  = wr && (wa[15:4] == ra[15:4]);
    foreach (q_addr[k]) if (q_addr[k][15:4] == ra[15:4]) cfl = 1;
    cfl  = cfl && rc;
    fd   = m_flush && fr && (n == 0);
    ea = 16'h0; ed = 16'h0;
    if (drn) begin ea = q_addr[0]; ed = q_data[0]; end
    check("mem_en", 16'(mem_en), 16'(drn));
    check("mem_wr", 16'(mem_wr), 16'(drn));
    check("mem_addr", mem_addr, ea);
    check("mem_data", mem_data, ed);
    check("wr_full", 16'(wr_full), 16'(full));
    check("conflict", 16'(conflict), 16'(cfl));
    check("flush_done", 16'(flush_done), 16'(fd));
    check("count", 16'(count), 16'(n));
    check("empty", 16'(empty), 16'(n == 0));
    obs_full = wr_full; obs_cfl = conflict; obs_fd = flush_done; obs_wr = mem_wr;
    obs_maddr = mem_addr; obs_mdata = mem_data;
    @(posedge clk);
    if (mrg) q_data[n-1] = wd;
    if (drn) begin void'(q_addr.pop_front()); void'(q_data.pop_front()); end
    if (acc) begin q_addr.push_back(wa); q_data.push_back(wd); end
    m_flush = m_flush ? (fr && n != 0) : fr;
    @(negedge clk);
  endtask

  task automatic idle(input logic fb);
    step(1'b0, 16'h0, 16'h0, fb, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    bit          fr;
    logic [15:0] wa, ra;

    do_reset();
    #1;
    check("rst_empty", 16'(empty), 16'h1);
    check("rst_count", 16'(count), 16'h0);
    check("rst_full", 16'(wr_full), 16'h0);
    check("rst_mem_wr", 16'(mem_wr), 16'h0);
    check("rst_mem_addr", mem_addr, 16'h0);
    @(negedge clk);

    // Three stores drain on the following cycles, in order.
    step(1'b1, 16'h0010, 16'h1111, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0020, 16'h2222, 1'b0, 1'b0, 16'h0, 1'b0);
    check("t1_first_drain", obs_maddr, 16'h0010);
    step(1'b1, 16'h0030, 16'h3333, 1'b0, 1'b0, 16'h0, 1'b0);
    check("t1_second_drain", obs_mdata, 16'h2222);
    idle(1'b0);
    check("t1_third_drain", obs_maddr, 16'h0030);
    idle(1'b0);
    check("t1_count_zero", 16'(count), 16'h0);

    // Fill up with fill_busy, then wrap the pointers.
    for (int i = 0; i < 4; i++)
      step(1'b1, 16'h0100 + 16'(2 * i), 16'hC000 + 16'(i), 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0108, 16'hC004, 1'b1, 1'b0, 16'h0, 1'b0);
    check("t2_full", 16'(obs_full), 16'h1);
    step(1'b1, 16'h0108, 16'hC004, 1'b0, 1'b0, 16'h0, 1'b0);
    check("t2_full_during_drain", 16'(obs_full), 16'h1);
    check("t2_drain_head", obs_maddr, 16'h0100);
    step(1'b1, 16'h0108, 16'hC004, 1'b0, 1'b0, 16'h0, 1'b0);
    check("t2_accept_next", 16'(obs_full), 16'h0);
    for (int i = 0; i < 5; i++) idle(1'b0);

    // Merge into the newest entry.
    step(1'b1, 16'h0040, 16'hAAAA, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0040, 16'hBBBB, 1'b1, 1'b0, 16'h0, 1'b0);
    check("t3_count_one", 16'(count), 16'h1);
    idle(1'b0);
    check("t3_merged_data", obs_mdata, 16'hBBBB);
    idle(1'b0);
    check("t3_single_write", 16'(obs_wr), 16'h0);

    // Block conflict until the store drains.
    step(1'b1, 16'h0046, 16'h4646, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0040, 1'b0);
    check("t4_conflict_held", 16'(obs_cfl), 16'h1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0040, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0040, 1'b0);
    check("t4_conflict_clear", 16'(obs_cfl), 16'h0);
    step(1'b1, 16'h0058, 16'h5858, 1'b1, 1'b1, 16'h0050, 1'b0);
    check("t4_wr_conflict", 16'(obs_cfl), 16'h1);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0040, 1'b0);
    check("t4_other_block", 16'(obs_cfl), 16'h0);
    for (int i = 0; i < 2; i++) idle(1'b0);

    // Flush with fill_busy toggling; drop flush_req once done pulses.
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'h0600 + 16'(4 * i), 16'h6000 + 16'(i), 1'b1, 1'b0, 16'h0, 1'b0);
    fr = 1; pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(fr, 16'h0700, 16'h7777, 1'(i % 2), 1'b0, 16'h0, fr);
      if (fr) check("t5_full_in_flush", 16'(obs_full), 16'h1);
      pulses += int'(obs_fd);
      if (obs_fd) fr = 0;
    end
    check("t5_single_pulse", 16'(pulses), 16'h1);
    for (int i = 0; i < 3; i++) idle(1'b0);

    // Reset with entries pending discards them.
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'h0800 + 16'(2 * i), 16'h8000 + 16'(i), 1'b1, 1'b0, 16'h0, 1'b0);
    do_reset();
    idle(1'b0);
    check("t6_no_write", 16'(obs_wr), 16'h0);
    check("t6_count", 16'(count), 16'h0);
    check("t6_full", 16'(wr_full), 16'h0);

    // Randomized traffic with merges, conflicts and flushes.
    fr = 0;
    for (int i = 0; i < 400; i++) begin
      wa = {11'h010, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0,
            1'($urandom_range(0, 1))};
      ra = ($urandom_range(0, 2) == 0) ? 16'h0300 : {11'h010, 1'($urandom_range(0, 1)), 4'h0};
      if ($urandom_range(0, 15) == 0) fr = ~fr;
      step(1'($urandom_range(0, 9) < 6), wa, 16'($urandom), 1'($urandom_range(0, 9) < 4),
           1'($urandom_range(0, 1)), ra, fr);
    end
    for (int i = 0; i < 10; i++) idle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
